// File: rtl/sram_burst_controller_if.sv
// CPU-side request/response bundle of the SRAM burst controller.
// The controller takes the slave modport; the Memory stage (or a bench) drives the master side.
interface sram_burst_controller_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] write_data;
  logic [WORD_W-1:0] read_data;
  logic              read_valid;
  logic              ready;

  modport master (
    output read_enable, write_enable, address, write_data,
    input  read_data, read_valid, ready
  );

  modport slave (
    input  read_enable, write_enable, address, write_data,
    output read_data, read_valid, ready
  );
endinterface

// File: rtl/sram_burst_controller.sv
// Splits one CPU word access into WORD_W/SRAM_DW beats on an asynchronous SRAM, MSB slice first.
// Optional macro SRAM_POSTED_WRITE_EN lets writes complete in the background.
module sram_burst_controller #(
  parameter int WORD_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int ADDR_W      = 32,
  parameter int BEAT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  sram_burst_controller_if.slave bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);
  localparam int BEATS = WORD_W / SRAM_DW;
  localparam int LB    = $clog2(BEATS);
  localparam int BW    = (LB > 0) ? LB : 1;
  localparam int CW    = $clog2(BEAT_CYCLES);
  localparam int WB    = $clog2(WORD_W / 8);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(BEAT_CYCLES - 1);

`ifdef SRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t             r_state;
  logic [BW-1:0]      r_beat;
  logic [CW-1:0]      r_cyc;
  logic [SRAM_AW-1:0] r_word_idx;
  logic [WORD_W-1:0]  r_wdata;
  logic [WORD_W-1:0]  r_shadow;
  logic [WORD_W-1:0]  r_read_data;
  logic               r_read_valid;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_dq_out;
  logic               r_dq_oe;
  logic               r_we_n;
  logic               r_oe_n;
  logic               r_ce_n;
  logic               r_bytes_n;

  logic               w_request;
  logic [SRAM_AW-1:0] w_req_idx;
  logic [BW-1:0]      w_next_beat;
  logic [CW-1:0]      w_next_cyc;
  logic [WORD_W-1:0]  w_shadow_next;
  logic               w_ready;

  function automatic logic [SRAM_DW-1:0] slice_of(input logic [WORD_W-1:0] word,
                                                  input logic [BW-1:0] beat);
    return word[WORD_W-1-int'(beat)*SRAM_DW -: SRAM_DW];
  endfunction

  // Left shift by LB drops the word-index bits that do not fit next to the beat number.
  function automatic logic [SRAM_AW-1:0] beat_addr(input logic [SRAM_AW-1:0] word_idx,
                                                   input logic [BW-1:0] beat);
    return (word_idx << LB) | SRAM_AW'(beat);
  endfunction

  assign w_request   = bus.read_enable || bus.write_enable;
  assign w_req_idx   = SRAM_AW'(bus.address >> WB);
  assign w_next_beat = r_beat + BW'(1);
  assign w_next_cyc  = r_cyc + CW'(1);

  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[WORD_W-1-int'(r_beat)*SRAM_DW -: SRAM_DW] = SRAM_DQ;
  end

  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      S_IDLE:  w_ready = POSTED ? !bus.read_enable : !w_request;
      S_READ:  w_ready = 1'b0;
      S_WRITE: w_ready = POSTED ? !w_request : 1'b0;
      S_DONE:  w_ready = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<='; datapath holding registers are not reset since
  // they are always loaded before being observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_cyc        <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_sram_addr  <= '0;
      r_dq_oe      <= 1'b0;
      r_we_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_ce_n       <= 1'b1;
      r_bytes_n    <= 1'b1;
    end else begin
      r_read_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_request) begin
            r_word_idx  <= w_req_idx;
            r_wdata     <= bus.write_data;
            r_beat      <= '0;
            r_cyc       <= '0;
            r_sram_addr <= beat_addr(w_req_idx, '0);
            r_ce_n      <= 1'b0;
            r_bytes_n   <= 1'b0;
            if (bus.read_enable) begin
              r_state <= S_READ;
              r_oe_n  <= 1'b0;
            end else begin
              r_state  <= S_WRITE;
              r_we_n   <= 1'b0;
              r_dq_oe  <= 1'b1;
              r_dq_out <= slice_of(bus.write_data, '0);
            end
          end
        end
        S_READ, S_WRITE: begin
          if (r_state == S_READ && r_cyc == LAST_CYC) r_shadow <= w_shadow_next;
          if (r_cyc != LAST_CYC) begin
            r_cyc <= w_next_cyc;
            // WE_N rises for the final cycle of a beat while address and data stay put.
            if (r_state == S_WRITE) r_we_n <= (w_next_cyc == LAST_CYC);
          end else if (r_beat != LAST_BEAT) begin
            r_cyc       <= '0;
            r_beat      <= w_next_beat;
            r_sram_addr <= beat_addr(r_word_idx, w_next_beat);
            if (r_state == S_WRITE) begin
              r_we_n   <= 1'b0;
              r_dq_out <= slice_of(r_wdata, w_next_beat);
            end
          end else begin
            r_cyc     <= '0;
            r_beat    <= '0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_bytes_n <= 1'b1;
            r_dq_oe   <= 1'b0;
            if (r_state == S_READ) begin
              r_read_data  <= w_shadow_next;
              r_read_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state <= POSTED ? S_IDLE : S_DONE;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
  assign bus.ready      = w_ready;
  assign SRAM_DQ        = r_dq_oe ? r_dq_out : 'z;
  assign SRAM_ADDR      = r_sram_addr;
  assign SRAM_UB_N      = r_bytes_n;
  assign SRAM_LB_N      = r_bytes_n;
  assign SRAM_WE_N      = r_we_n;
  assign SRAM_CE_N      = r_ce_n;
  assign SRAM_OE_N      = r_oe_n;
endmodule

// File: tb/tb_sram_burst_controller.sv
// Bench for sram_burst_controller: a 32-bit/3-cycle instance with a behavioural SRAM and word-level
// reference map, plus a 64-bit/2-cycle instance for the wide-word read.
module tb_sram_burst_controller;
  localparam int N32 = 2 * 3;
  localparam int N64 = 4 * 2;
`ifdef SRAM_POSTED_WRITE_EN
  localparam int WR_LOW  = 0;
  localparam int B2B_LOW = 2 * N32 + 1;
`else
  localparam int WR_LOW  = N32 + 1;
  localparam int B2B_LOW = N32 + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  sram_burst_controller_if #(.WORD_W(32), .ADDR_W(32)) bus32 ();
  sram_burst_controller_if #(.WORD_W(64), .ADDR_W(32)) bus64 ();

  wire  [15:0] dq32, dq64;
  logic [17:0] addr32, addr64;
  logic ub32, lb32, we32, ce32, oe32;
  logic ub64, lb64, we64, ce64, oe64;

  sram_burst_controller #(.WORD_W(32), .SRAM_DW(16), .SRAM_AW(18), .ADDR_W(32), .BEAT_CYCLES(3)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32), .SRAM_DQ(dq32), .SRAM_ADDR(addr32),
    .SRAM_UB_N(ub32), .SRAM_LB_N(lb32), .SRAM_WE_N(we32), .SRAM_CE_N(ce32), .SRAM_OE_N(oe32)
  );

  sram_burst_controller #(.WORD_W(64), .SRAM_DW(16), .SRAM_AW(18), .ADDR_W(32), .BEAT_CYCLES(2)) dut64 (
    .clk(clk), .rst(rst), .bus(bus64), .SRAM_DQ(dq64), .SRAM_ADDR(addr64),
    .SRAM_UB_N(ub64), .SRAM_LB_N(lb64), .SRAM_WE_N(we64), .SRAM_CE_N(ce64), .SRAM_OE_N(oe64)
  );

  // Asynchronous SRAM models: drive DQ while selected for read, store while WE_N is low.
  logic [15:0] mem32 [0:262143];
  logic [15:0] mem64 [0:262143];
  logic        pl_en32 = 1'b0;
  logic        pl_en64 = 1'b0;
  logic [17:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign dq32 = (!ce32 && !oe32 && we32) ? mem32[addr32] : 'z;
  assign dq64 = (!ce64 && !oe64 && we64) ? mem64[addr64] : 'z;

  always @(posedge clk) begin
    if (pl_en32) mem32[pl_addr] <= pl_data;
    else if (!ce32 && !we32) mem32[addr32] <= dq32;
  end

  always @(posedge clk) begin
    if (pl_en64) mem64[pl_addr] <= pl_data;
    else if (!ce64 && !we64) mem64[addr64] <= dq64;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic preload(input bit wide, input logic [17:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    if (wide) pl_en64 = 1'b1; else pl_en32 = 1'b1;
    @(posedge clk); #1;
    pl_en32 = 1'b0;
    pl_en64 = 1'b0;
  endtask

  task automatic idle(input int n);
    bus32.read_enable  = 1'b0;
    bus32.write_enable = 1'b0;
    bus64.read_enable  = 1'b0;
    bus64.write_enable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request on the 32-bit instance; returns stall length and strobe counts over the access.
  task automatic access32(input bit re, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic rv, output int low,
                          output int ce_low, output int oe_low, output int we_low);
    bus32.read_enable  = re;
    bus32.write_enable = we;
    bus32.address      = a;
    bus32.write_data   = wd;
    low = 0; ce_low = 0; oe_low = 0; we_low = 0;
    #1;
    while (!bus32.ready && low < 100) begin
      low++;
      @(posedge clk); #1;
      if (!ce32) ce_low++;
      if (!oe32) oe_low++;
      if (!we32) we_low++;
    end
    check("access32 timeout", 64'(low < 100), 64'd1);
    rd = bus32.read_data;
    rv = bus32.read_valid;
    @(posedge clk); #1;
  endtask

  // Reference map keyed by CPU word index (17 bits survive the SRAM address).
  logic [31:0] ref_words [int];

  function automatic int word_key(input logic [31:0] a);
    return int'((a >> 2) & 32'h1FFFF);
  endfunction

  initial begin
    logic [31:0] rd, wd, a;
    logic        rv;
    int          low, ce_low, oe_low, we_low, pulses, key;
    logic [31:0] addrs [$];

    bus32.read_enable = 1'b0; bus32.write_enable = 1'b0; bus32.address = '0; bus32.write_data = '0;
    bus64.read_enable = 1'b0; bus64.write_enable = 1'b0; bus64.address = '0; bus64.write_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset ready", 64'(bus32.ready), 64'd1);
    check("reset read_valid", 64'(bus32.read_valid), 64'd0);
    check("reset read_data", 64'(bus32.read_data), 64'd0);
    check("reset ctrl", {59'd0, ce32, oe32, we32, ub32, lb32}, 64'h1F);
    check("reset sram_addr", 64'(addr32), 64'd0);

    // Word index 0x80 maps to SRAM words 0x100/0x101.
    preload(1'b0, 18'h00100, 16'h1234);
    preload(1'b0, 18'h00101, 16'hABCD);
    access32(1'b1, 1'b0, 32'h200, 32'h0, rd, rv, low, ce_low, oe_low, we_low);
    check("read ready low", 64'(low), 64'(N32 + 1));
    check("read data", 64'(rd), 64'h1234ABCD);
    check("read valid in done", 64'(rv), 64'd1);
    check("read oe cycles", 64'(oe_low), 64'(N32));
    check("read valid one cycle", 64'(bus32.read_valid), 64'd0);
    idle(1);

    access32(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, rd, rv, low, ce_low, oe_low, we_low);
    check("write ready low", 64'(low), 64'(WR_LOW));
`ifndef SRAM_POSTED_WRITE_EN
    check("write we_n low cycles", 64'(we_low), 64'd4);
    check("write ce_n low cycles", 64'(ce_low), 64'(N32));
    check("write no read_valid", 64'(rv), 64'd0);
`endif
    idle(N32 + 2);
    check("write hi slice", 64'(mem32[4]), 64'hDEAD);
    check("write lo slice", 64'(mem32[5]), 64'hBEEF);
    check("post-write ctrl", {59'd0, ce32, oe32, we32, ub32, lb32}, 64'h1F);
    ref_words[word_key(32'h8)] = 32'hDEADBEEF;

    // Both enables: the read wins and the SRAM keeps its contents.
    access32(1'b1, 1'b1, 32'h8, 32'h55555555, rd, rv, low, ce_low, oe_low, we_low);
    check("both-enable read data", 64'(rd), 64'hDEADBEEF);
    check("both-enable no write", 64'(we_low), 64'd0);
    idle(2);
    check("both-enable mem intact", 64'(mem32[5]), 64'hBEEF);

    // Back-to-back write then read of the same word with no idle gap.
    access32(1'b0, 1'b1, 32'h40, 32'h11112222, rd, rv, low, ce_low, oe_low, we_low);
    access32(1'b1, 1'b0, 32'h40, 32'h0, rd, rv, low, ce_low, oe_low, we_low);
    check("b2b read ready low", 64'(low), 64'(B2B_LOW));
    check("b2b read data", 64'(rd), 64'h11112222);
    check("b2b read valid", 64'(rv), 64'd1);
    ref_words[word_key(32'h40)] = 32'h11112222;
    idle(1);

    // Reset during the third READ cycle abandons the access.
    bus32.read_enable = 1'b1;
    bus32.address     = 32'h200;
    repeat (3) @(posedge clk);
    #1;
    check("mid-read in progress", 64'(oe32), 64'd0);
    rst = 1'b1;
    bus32.read_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-reset ready", 64'(bus32.ready), 64'd1);
    check("mid-reset ctrl", {59'd0, ce32, oe32, we32, ub32, lb32}, 64'h1F);
    check("mid-reset read_data", 64'(bus32.read_data), 64'd0);
    check("mid-reset sram_addr", 64'(addr32), 64'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus32.read_valid) pulses++;
      @(posedge clk); #1;
    end
    check("mid-reset no valid pulse", 64'(pulses), 64'd0);

    // Random writes checked at the pins, then aliased reads checked against the reference map.
    for (int i = 0; i < 10; i++) begin
      a  = $urandom;
      wd = $urandom;
      access32(1'b0, 1'b1, a, wd, rd, rv, low, ce_low, oe_low, we_low);
      idle(N32 + 2);
      key = word_key(a);
      ref_words[key] = wd;
      addrs.push_back(a);
      check("rand write hi", 64'(mem32[18'(key * 2)]), 64'(wd[31:16]));
      check("rand write lo", 64'(mem32[18'(key * 2 + 1)]), 64'(wd[15:0]));
    end
    foreach (addrs[i]) begin
      a = addrs[i] ^ ({$urandom} << 19) ^ 32'(i % 4);
      access32(1'b1, 1'b0, a, 32'h0, rd, rv, low, ce_low, oe_low, we_low);
      check("rand read data", 64'(rd), 64'(ref_words[word_key(addrs[i])]));
      check("rand read low", 64'(low), 64'(N32 + 1));
      idle(1);
    end

    // Wide word: 4 beats of 2 cycles, beat 0 is the most significant slice.
    preload(1'b1, 18'h00040, 16'h0102);
    preload(1'b1, 18'h00041, 16'h0304);
    preload(1'b1, 18'h00042, 16'h0506);
    preload(1'b1, 18'h00043, 16'h0708);
    bus64.read_enable = 1'b1;
    bus64.address     = 32'h80;
    low = 0;
    #1;
    while (!bus64.ready && low < 100) begin
      low++;
      @(posedge clk); #1;
    end
    check("wide read ready low", 64'(low), 64'(N64 + 1));
    check("wide read data", bus64.read_data, 64'h0102030405060708);
    check("wide read valid", 64'(bus64.read_valid), 64'd1);
    @(posedge clk); #1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t limit %0t", $time, 2000000);
    $fatal(1, "watchdog");
  end
endmodule
